// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared elaboration-time helpers for common blocks
package common_pkg;

   // Ceiling log2: number of bits to encode values 0..n-1.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Pointer width that never collapses to zero bits for single-entry storage.
   function automatic int ptr_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/common_wrap_counter.sv
// rtl/common_wrap_counter.sv - modulo-MAX up counter with synchronous clear
module common_wrap_counter
   import common_pkg::*;
#(
   parameter int MAX = 4,
   localparam int W = ptr_width(MAX)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] value
);

   logic at_last;

   // Explicit terminal compare so non-power-of-two MAX wraps correctly.
   assign at_last = (value == W'(MAX - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value <= '0;
      end else if (clear) begin
         value <= '0;
      end else if (inc) begin
         value <= at_last ? '0 : value + W'(1);
      end
   end

endmodule

// File: rtl/common_bypass_fifo.sv
// rtl/common_bypass_fifo.sv - valid/ready FIFO with zero-latency bypass when empty
module common_bypass_fifo
   import common_pkg::*;
#(
   parameter int BUFFER_WIDTH = 32,
   parameter int BUFFER_DEPTH = 4,
   parameter int COUNT_WIDTH  = clog2(BUFFER_DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic [BUFFER_WIDTH-1:0] prev_i_data,
   input  logic                    prev_i_valid,
   output logic                    prev_o_ready,
   output logic [BUFFER_WIDTH-1:0] next_o_data,
   output logic                    next_o_valid,
   input  logic                    next_i_ready,
   output logic [COUNT_WIDTH-1:0]  o_count,
   output logic                    o_empty,
   output logic                    o_full
);

   localparam int PTR_W = ptr_width(BUFFER_DEPTH);

   logic [BUFFER_WIDTH-1:0] mem [BUFFER_DEPTH];
   logic [PTR_W-1:0]        head;
   logic [PTR_W-1:0]        tail;
   logic [COUNT_WIDTH-1:0]  count;

   logic empty;
   logic full;
   logic push_in;
   logic pop_out;
   logic wr_en;
   logic rd_en;

   assign empty = (count == '0);
   assign full  = (count == COUNT_WIDTH'(BUFFER_DEPTH));

   // Ready looks only at registered occupancy, keeping next_i_ready off this path.
   assign prev_o_ready = !full && !flush;
   assign push_in      = prev_i_valid && prev_o_ready;

   assign next_o_valid = empty ? (prev_i_valid && !flush) : !flush;
   assign next_o_data  = empty ? prev_i_data : mem[head];
   assign pop_out      = next_o_valid && next_i_ready;

   // A beat that passes straight through an empty FIFO touches no storage.
   assign wr_en = push_in && !(empty && next_i_ready);
   assign rd_en = pop_out && !empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else begin
         case ({wr_en, rd_en})
            2'b10:   count <= count + COUNT_WIDTH'(1);
            2'b01:   count <= count - COUNT_WIDTH'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[tail] <= prev_i_data;
      end
   end

   common_wrap_counter #(
      .MAX(BUFFER_DEPTH)
   ) u_head (
      .clk   (clk),
      .reset (reset),
      .clear (flush),
      .inc   (rd_en),
      .value (head)
   );

   common_wrap_counter #(
      .MAX(BUFFER_DEPTH)
   ) u_tail (
      .clk   (clk),
      .reset (reset),
      .clear (flush),
      .inc   (wr_en),
      .value (tail)
   );

   assign o_count = count;
   assign o_empty = empty;
   assign o_full  = full;

endmodule

// File: tb/tb_common_bypass_fifo.sv
// tb/tb_common_bypass_fifo.sv - scoreboard bench for depth-4 and depth-3 bypass FIFOs
module tb_common_bypass_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [31:0] pd [2];
   logic        pv [2];
   logic        nr [2];
   logic        fl [2];

   logic        pr0, nv0, emp0, ful0;
   logic        pr1, nv1, emp1, ful1;
   logic [31:0] nd0, nd1;
   logic [2:0]  c4;
   logic [1:0]  c3;

   int          n_vec = 0;
   int          n_err = 0;
   int          mcnt [2];
   int          nrecv [2];
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   logic        acc;

   common_bypass_fifo #(.BUFFER_WIDTH(32), .BUFFER_DEPTH(4)) u_d4 (
      .clk          (clk),
      .reset        (reset),
      .flush        (fl[0]),
      .prev_i_data  (pd[0]),
      .prev_i_valid (pv[0]),
      .prev_o_ready (pr0),
      .next_o_data  (nd0),
      .next_o_valid (nv0),
      .next_i_ready (nr[0]),
      .o_count      (c4),
      .o_empty      (emp0),
      .o_full       (ful0)
   );

   common_bypass_fifo #(.BUFFER_WIDTH(32), .BUFFER_DEPTH(3)) u_d3 (
      .clk          (clk),
      .reset        (reset),
      .flush        (fl[1]),
      .prev_i_data  (pd[1]),
      .prev_i_valid (pv[1]),
      .prev_o_ready (pr1),
      .next_o_data  (nd1),
      .next_o_valid (nv1),
      .next_i_ready (nr[1]),
      .o_count      (c3),
      .o_empty      (emp1),
      .o_full       (ful1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] obs_cnt(input int s);
      return (s == 0) ? {29'b0, c4} : {30'b0, c3};
   endfunction

   // One clock of stimulus on instance s, checked against the occupancy model and scoreboard.
   task automatic cycle(input int s, input logic v, input logic [31:0] d, input logic r,
                        input logic f, output logic accepted);
      int          dep;
      logic        m_ready, m_valid, m_push, m_pop;
      logic [31:0] exp_d;
      dep   = (s == 0) ? 4 : 3;
      pv[s] = v;
      pd[s] = d;
      nr[s] = r;
      fl[s] = f;
      #1;
      m_ready = (mcnt[s] != dep) && !f;
      m_push  = v && m_ready;
      m_valid = !f && (mcnt[s] != 0 || v);
      m_pop   = m_valid && r;
      chk("count", obs_cnt(s), 32'(mcnt[s]));
      chk("empty", {31'b0, (s == 0) ? emp0 : emp1}, {31'b0, mcnt[s] == 0});
      chk("full",  {31'b0, (s == 0) ? ful0 : ful1}, {31'b0, mcnt[s] == dep});
      chk("ready", {31'b0, (s == 0) ? pr0 : pr1},   {31'b0, m_ready});
      chk("valid", {31'b0, (s == 0) ? nv0 : nv1},   {31'b0, m_valid});
      if (m_push) begin
         if (s == 0) q0.push_back(d);
         else        q1.push_back(d);
      end
      if (m_pop) begin
         if (s == 0) exp_d = q0.pop_front();
         else        exp_d = q1.pop_front();
         chk("data", (s == 0) ? nd0 : nd1, exp_d);
         nrecv[s]++;
      end
      if (f) begin
         if (s == 0) q0.delete();
         else        q1.delete();
         mcnt[s] = 0;
      end else begin
         mcnt[s] = mcnt[s] + int'(m_push) - int'(m_pop);
      end
      accepted = m_push;
      @(posedge clk);
      @(negedge clk);
      pv[s] = 1'b0;
      nr[s] = 1'b0;
      fl[s] = 1'b0;
   endtask

   initial begin
      int k;
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         pd[i] = '0; pv[i] = 1'b0; nr[i] = 1'b0; fl[i] = 1'b0;
         mcnt[i] = 0; nrecv[i] = 0;
      end
      @(negedge clk);
      @(negedge clk);
      pv[0] = 1'b1;
      pd[0] = 32'h0000_0055;
      #1;
      chk("rst_count", obs_cnt(0), 32'd0);
      chk("rst_empty", {31'b0, emp0}, 32'd1);
      chk("rst_full",  {31'b0, ful0}, 32'd0);
      chk("rst_ready", {31'b0, pr0},  32'd1);
      chk("rst_valid", {31'b0, nv0},  32'd1);
      chk("rst_data",  nd0, 32'h0000_0055);
      pv[0] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Bypass on empty FIFO
      cycle(0, 1'b1, 32'h1111_1111, 1'b1, 1'b0, acc);
      chk("bypass_count", obs_cnt(0), 32'd0);

      // Fill to full with backpressure; fifth beat refused
      for (int i = 0; i < 5; i++) cycle(0, 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, acc);
      chk("full_refuse", {31'b0, acc}, 32'd0);
      // Pop while full: no push this cycle, push accepted the next
      cycle(0, 1'b1, 32'hA4, 1'b1, 1'b0, acc);
      chk("full_pop_nopush", {31'b0, acc}, 32'd0);
      cycle(0, 1'b1, 32'hA4, 1'b1, 1'b0, acc);
      chk("after_full_push", {31'b0, acc}, 32'd1);
      for (int i = 0; i < 3; i++) cycle(0, 1'b0, 32'h0, 1'b1, 1'b0, acc);
      chk("drain_empty", 32'(q0.size()), 32'd0);
      chk("drain_recv", 32'(nrecv[0]), 32'd6);

      // Depth-3 wrap under random backpressure
      k = 0;
      for (int c = 0; c < 200 && nrecv[1] < 10; c++) begin
         cycle(1, k < 10, 32'hC0 + 32'(k), (c < 3) ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0, acc);
         if (acc) k++;
      end
      chk("wrap_recv", 32'(nrecv[1]), 32'd10);
      chk("wrap_sb_empty", 32'(q1.size()), 32'd0);

      // Flush with two stored entries
      cycle(0, 1'b1, 32'hB0, 1'b0, 1'b0, acc);
      cycle(0, 1'b1, 32'hB1, 1'b0, 1'b0, acc);
      cycle(0, 1'b1, 32'hB2, 1'b1, 1'b1, acc);
      cycle(0, 1'b1, 32'hB3, 1'b1, 1'b0, acc);
      chk("flush_bypass_count", obs_cnt(0), 32'd0);

      // Asynchronous reset between edges with three stored entries
      for (int i = 0; i < 3; i++) cycle(0, 1'b1, 32'hD0 + 32'(i), 1'b0, 1'b0, acc);
      chk("pre_areset_count", obs_cnt(0), 32'd3);
      #2;
      reset = 1'b0;
      #1;
      chk("areset_count", obs_cnt(0), 32'd0);
      chk("areset_empty", {31'b0, emp0}, 32'd1);
      chk("areset_ready", {31'b0, pr0}, 32'd1);
      q0.delete();
      mcnt[0] = 0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      cycle(0, 1'b1, 32'hE0E0_E0E0, 1'b1, 1'b0, acc);
      cycle(0, 1'b0, 32'h0, 1'b0, 1'b0, acc);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
